// File: rtl/bus_arbiter.sv
// bus_arbiter: fair coherence-request arbiter in front of the MESI bus controller.
// Winner = starving requester if any, else highest request class; ties broken
// round-robin from rr_ptr. Grant is held until accepted, then tracked to completion.
module bus_arbiter #(
   parameter int CACHES       = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CACHES-1:0]         dREN,
   input  logic [CACHES-1:0]         dWEN,
   input  logic [CACHES-1:0]         ccwrite,
   input  logic                      bus_accept,
   input  logic                      bus_done,
   output logic                      grant_valid,
   output logic [$clog2(CACHES)-1:0] grant_id,
   output logic [CACHES-1:0]         grant_onehot,
   output logic [1:0]                grant_type,
   output logic                      busy
);

   localparam int IW = $clog2(CACHES);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     grant_id_q, grant_id_d;
   logic [1:0]        grant_type_q, grant_type_d;
   logic [CACHES-1:0] grant_onehot_q, grant_onehot_d;
   logic [CW-1:0]     cnt_q [CACHES];
   logic [CW-1:0]     cnt_d [CACHES];

   logic [CACHES-1:0] pend;
   logic [1:0]        typ [CACHES];
   logic              any_pend;
   logic [1:0]        top_cls;
   logic              found_s, found_c;
   logic [IW-1:0]     starve_id, class_id, win_id;
   logic [1:0]        win_type;

   // Classify each cache's request: EVICT > READ_X > READ > INV.
   always_comb begin
      pend     = '0;
      any_pend = 1'b0;
      top_cls  = 2'b00;
      for (int i = 0; i < CACHES; i++) begin
         pend[i] = dWEN[i] | dREN[i] | ccwrite[i];
         if (dWEN[i])                      typ[i] = 2'b11;
         else if (dREN[i] && ccwrite[i])   typ[i] = 2'b10;
         else if (dREN[i])                 typ[i] = 2'b01;
         else                              typ[i] = 2'b00;
         if (pend[i]) begin
            any_pend = 1'b1;
            if (typ[i] > top_cls) top_cls = typ[i];
         end
      end
   end

   // Scan from rr_ptr: first starving cache wins, else first of the top class.
   always_comb begin
      found_s   = 1'b0;
      found_c   = 1'b0;
      starve_id = '0;
      class_id  = '0;
      for (int k = 0; k < CACHES; k++) begin
         int            sum;
         logic [IW-1:0] idx;
         sum = int'(rr_ptr_q) + k;
         if (sum >= CACHES) sum = sum - CACHES;
         idx = IW'(sum);
         if (!found_s && pend[idx] && (cnt_q[idx] == LIMIT)) begin
            found_s   = 1'b1;
            starve_id = idx;
         end
         if (!found_c && pend[idx] && (typ[idx] == top_cls)) begin
            found_c  = 1'b1;
            class_id = idx;
         end
      end
      win_id   = found_s ? starve_id : class_id;
      win_type = typ[win_id];
   end

   // Next-state, grant latching, round-robin and aging counter updates.
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_id_d     = grant_id_q;
      grant_type_d   = grant_type_q;
      grant_onehot_d = grant_onehot_q;
      cnt_d          = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_pend) begin
               state_d        = S_GRANT;
               grant_id_d     = win_id;
               grant_type_d   = win_type;
               grant_onehot_d = CACHES'(1) << win_id;
            end
         end
         S_GRANT: begin
            // Accept beats a simultaneous withdrawal.
            if (bus_accept) begin
               state_d = S_BUSY;
            end else if (!pend[grant_id_q]) begin
               state_d        = S_IDLE;
               grant_id_d     = '0;
               grant_type_d   = '0;
               grant_onehot_d = '0;
            end
         end
         S_BUSY: begin
            if (bus_done) begin
               state_d        = S_IDLE;
               grant_onehot_d = '0;
               rr_ptr_d       = (int'(grant_id_q) == CACHES - 1) ? '0 : grant_id_q + 1'b1;
               for (int i = 0; i < CACHES; i++) begin
                  if (IW'(i) == grant_id_q)  cnt_d[i] = '0;
                  else if (pend[i])          cnt_d[i] = (cnt_q[i] == LIMIT) ? LIMIT : cnt_q[i] + 1'b1;
                  else                       cnt_d[i] = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and grant registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= S_IDLE;
         rr_ptr_q       <= '0;
         grant_id_q     <= '0;
         grant_type_q   <= '0;
         grant_onehot_q <= '0;
         for (int i = 0; i < CACHES; i++) cnt_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_id_q     <= grant_id_d;
         grant_type_q   <= grant_type_d;
         grant_onehot_q <= grant_onehot_d;
         cnt_q          <= cnt_d;
      end
   end

   assign grant_valid  = (state_q == S_GRANT);
   assign busy         = (state_q == S_BUSY);
   assign grant_id     = grant_id_q;
   assign grant_type   = grant_type_q;
   assign grant_onehot = grant_onehot_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Fair request arbiter in front of the MESI bus controller. Replaces its fixed lowest-index-wins priority encoding.
- Classifies each L1 cache's pending coherence request and picks one winner per bus transaction: class priority first, then round-robin within the class, with an aging override so no cache starves.
- Holds the grant until the bus controller accepts it, then tracks the transaction until the controller signals completion.

Parameters:
- CACHES, 4: number of L1 requesters.
- STARVE_LIMIT, 3: number of lost arbitrations after which a requester overrides class priority. Must be ≥1.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- dREN  input  CACHES  per-cache read request (level)
- dWEN  input  CACHES  per-cache eviction/writeback request (level)
- ccwrite  input  CACHES  per-cache write intent (level)
- bus_accept  input  1  bus controller takes the offered grant
- bus_done  input  1  one-cycle pulse; granted transaction finished
- grant_valid  output  1  grant offered
- grant_id  output  $clog2(CACHES)  granted cache index
- grant_onehot  output  CACHES  one-hot of grant_id; all zero when no grant
- grant_type  output  2  11=EVICT, 10=READ_X, 01=READ, 00=INV
- busy  output  1  transaction in flight

Behaviour:
- One clock. Reset is synchronous and active-high (CLK, RST). On RST high at an edge:
  - state=IDLE; all outputs 0; rr_ptr=0; all wait counters 0.
  - Applies in any state, including mid-BUSY: the in-flight grant is dropped silently.
- Per-cache type, by priority:
  - EVICT if dWEN[i];
  - else READ_X if dREN[i]&ccwrite[i];
  - else READ if dREN[i];
  - else INV if ccwrite[i];
  - else not pending.
- Winner selection (combinational, used only in IDLE):
  - (a) If any pending cache has wait count == STARVE_LIMIT, the winner is the first such cache scanning rr_ptr, rr_ptr+1, … modulo CACHES.
  - (b) Otherwise take the highest class present; the winner is the first cache of that class in the same scan order.
  - The grant type is the winner's own classified type.
- State IDLE:
  - If any cache is pending, register grant_id, grant_type and grant_onehot, and go to GRANT. grant_valid rises one cycle after the request is seen.
  - If nothing is pending, stay in IDLE.
- State GRANT:
  - grant_valid=1; outputs are stable.
  - If bus_accept is high, go to BUSY; grant_valid=0 next cycle.
  - Else, if the granted cache is no longer pending (all of its dREN/dWEN/ccwrite low), withdraw: go to IDLE and clear the grant outputs. Counters and rr_ptr are unchanged.
  - bus_accept in the same cycle as a withdrawal wins: go to BUSY.
  - Type changes while in GRANT are ignored; grant_type stays latched.
- State BUSY:
  - busy=1, grant_valid=0; grant_id, grant_type and grant_onehot are held.
  - On bus_done: go to IDLE and clear grant_onehot.
  - Also on bus_done: rr_ptr = (grant_id+1) mod CACHES.
  - Also on bus_done: the winner's counter is set to 0; each other cache pending in that cycle increments its counter, saturating at STARVE_LIMIT; non-pending caches reset to 0.
  - bus_accept in BUSY is ignored. bus_done in IDLE or GRANT is ignored.
- Throughput: the next grant_valid comes at the earliest 2 cycles after bus_done (IDLE cycle, then GRANT).
- Counter width is $clog2(STARVE_LIMIT+1). rr_ptr wraps from CACHES-1 to 0.
- Invariants:
  - grant_valid and busy are never both 1.
  - grant_onehot has at most one bit set.

Test Plan:
- Single requester: CACHES=4. dREN=0010 from cycle 0 → cycle 1: grant_valid=1, grant_id=1, grant_type=01, grant_onehot=0010. bus_accept in cycle 2 → cycle 3: busy=1, grant_valid=0. bus_done in cycle 4 → cycle 5: IDLE, rr_ptr=2.
- Class priority: dREN=0001 and dWEN=0100 in the same cycle → grant_id=2, grant_type=11. After completion → grant_id=0, type=01.
- Round-robin: dREN=1111 held. Accept in the first GRANT cycle; bus_done 2 cycles after accept → grant_id sequence 0,1,2,3,0. No grant_valid during BUSY.
- Starvation override: STARVE_LIMIT=3. ccwrite[3]=1 held (INV); dWEN[0]=1 and dWEN[1]=1 held (EVICT). Grants 0,1,0 → cache 3 counter reaches 3 → 4th grant is grant_id=3, type=00, despite EVICT pending. Cache 3 counter then resets to 0.
- Withdraw and tie: granted cache 1 drops dREN in GRANT with bus_accept=0 → next cycle grant_valid=0, IDLE, rr_ptr unchanged. Repeat with the drop and bus_accept in the same cycle → BUSY.
- Reset mid-operation: RST=1 for one cycle while BUSY with grant_id=2 → after the edge, all outputs 0 and rr_ptr=0. With dREN=0100 still held → a fresh grant_valid with grant_id=2 two cycles after RST falls.
